// File: rtl/garbage_scheduler.sv
// garbage_scheduler: two-player VS-mode attack/garbage controller.
// Converts line clears into attack lines and cancels them against the
// clearing player's own pending garbage. The remainder is queued for the
// opponent, and queued rows are injected into the opponent's board after a
// non-clearing lock. The block also keeps the per-player KO and line_sended
// counters.
//
// Optional feature macro: GARBAGE_COMBO_EN (per-player combo bonus).
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   game_en                          2P game state active
//   lock_1/2, clear_valid_1/2        lock pulse, clear pulse (same cycle)
//   clear_lines_1/2 [2:0]            rows cleared by the lock
//   topout_1/2                       board topped out
//   inject_ack_1/2                   datapath accepted injection
//   inject_req_1/2, inject_rows_1/2  injection request and row count
//   inject_hole_1/2 [3:0]            hole column of injected rows
//   pending_1/2 [4:0]                garbage queued against each player
//   line_sended, line_sended_2 [5:0] attack lines generated by P1/P2
//   ko, ko_2 [2:0]                   KOs scored by P1/P2
//
// Inject FSM (one per player)
//   state | meaning
//   IDLE  | no burst outstanding
//   REQ   | request held with latched rows/hole until inject_ack
module garbage_scheduler #(
  parameter int          MAX_PENDING = 12,
  parameter int          MAX_INJECT  = 4,
  parameter int          BOARD_COLS  = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_en,
  input  logic       lock_1,
  input  logic       lock_2,
  input  logic       clear_valid_1,
  input  logic       clear_valid_2,
  input  logic [2:0] clear_lines_1,
  input  logic [2:0] clear_lines_2,
  input  logic       topout_1,
  input  logic       topout_2,
  input  logic       inject_ack_1,
  input  logic       inject_ack_2,
  output logic       inject_req_1,
  output logic       inject_req_2,
  output logic [2:0] inject_rows_1,
  output logic [2:0] inject_rows_2,
  output logic [3:0] inject_hole_1,
  output logic [3:0] inject_hole_2,
  output logic [4:0] pending_1,
  output logic [4:0] pending_2,
  output logic [5:0] line_sended,
  output logic [5:0] line_sended_2,
  output logic [2:0] ko,
  output logic [2:0] ko_2
);

  typedef enum logic {IDLE, REQ} inj_state_t;

  localparam logic [6:0] MAXP = 7'(MAX_PENDING);
  localparam logic [4:0] MAXI = 5'(MAX_INJECT);
  localparam logic [4:0] COLS = 5'(BOARD_COLS);

  inj_state_t state_1, state_2, state_1_n, state_2_n;
  logic [2:0]  rows_1_n, rows_2_n;
  logic [3:0]  hole_1_n, hole_2_n, hole_new;
  logic [4:0]  pending_1_n, pending_2_n;
  logic [5:0]  ls_1_n, ls_2_n;
  logic [2:0]  ko_1_n, ko_2_n;
  logic [15:0] lfsr;
  logic        game_en_q;

  logic        top_1, top_2, clr_1, clr_2, lk_1, lk_2, ack_1, ack_2, rise;
  logic [2:0]  atk_1, atk_2;
  logic [4:0]  avail_1, avail_2, cancel_1, cancel_2, rem_1, rem_2;
  logic [6:0]  sum_1, sum_2, ls_sum_1, ls_sum_2;
  logic [4:0]  hole_raw;

  function automatic logic [2:0] base_attack(input logic [2:0] n);
    case (n)
      3'd2:    return 3'd1;
      3'd3:    return 3'd2;
      3'd4:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // A topout in the same cycle overrides that player's lock/clear.
  assign top_1 = game_en & topout_1;
  assign top_2 = game_en & topout_2;
  assign clr_1 = game_en & clear_valid_1 & ~topout_1;
  assign clr_2 = game_en & clear_valid_2 & ~topout_2;
  assign lk_1  = game_en & lock_1 & ~topout_1;
  assign lk_2  = game_en & lock_2 & ~topout_2;
  assign ack_1 = game_en & inject_ack_1 & (state_1 == REQ);
  assign ack_2 = game_en & inject_ack_2 & (state_2 == REQ);
  assign rise  = game_en & ~game_en_q;

`ifdef GARBAGE_COMBO_EN
  logic [3:0] combo_1, combo_2, combo_1_n, combo_2_n, combo_up_1, combo_up_2;

  function automatic logic [2:0] combo_bonus(input logic [3:0] c);
    if (c >= 4'd6)      return 3'd3;
    else if (c >= 4'd4) return 3'd2;
    else if (c >= 4'd2) return 3'd1;
    else                return 3'd0;
  endfunction

  assign combo_up_1 = (combo_1 == 4'd15) ? combo_1 : combo_1 + 4'd1;
  assign combo_up_2 = (combo_2 == 4'd15) ? combo_2 : combo_2 + 4'd1;

  always_comb begin
    combo_1_n = combo_1;
    combo_2_n = combo_2;
    if (!game_en || top_1)  combo_1_n = 4'd0;
    else if (lk_1 && clr_1) combo_1_n = combo_up_1;
    else if (lk_1)          combo_1_n = 4'd0;
    if (!game_en || top_2)  combo_2_n = 4'd0;
    else if (lk_2 && clr_2) combo_2_n = combo_up_2;
    else if (lk_2)          combo_2_n = 4'd0;
  end

  // Bonus is taken from the combo value after this lock's increment.
  assign atk_1 = base_attack(clear_lines_1) + combo_bonus((lk_1 && clr_1) ? combo_up_1 : combo_1);
  assign atk_2 = base_attack(clear_lines_2) + combo_bonus((lk_2 && clr_2) ? combo_up_2 : combo_2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      combo_1 <= 4'd0;
      combo_2 <= 4'd0;
    end else begin
      combo_1 <= combo_1_n;
      combo_2 <= combo_2_n;
    end
  end
`else
  assign atk_1 = base_attack(clear_lines_1);
  assign atk_2 = base_attack(clear_lines_2);
`endif

  // Rows already handed to the datapath can no longer be cancelled.
  assign avail_1  = pending_1 - ((state_1 == REQ) ? {2'b00, inject_rows_1} : 5'd0);
  assign avail_2  = pending_2 - ((state_2 == REQ) ? {2'b00, inject_rows_2} : 5'd0);
  assign cancel_1 = !clr_1 ? 5'd0 : (({2'b00, atk_1} < avail_1) ? {2'b00, atk_1} : avail_1);
  assign cancel_2 = !clr_2 ? 5'd0 : (({2'b00, atk_2} < avail_2) ? {2'b00, atk_2} : avail_2);
  assign rem_1    = clr_1 ? ({2'b00, atk_1} - cancel_1) : 5'd0;
  assign rem_2    = clr_2 ? ({2'b00, atk_2} - cancel_2) : 5'd0;

  // Ack subtraction, then cancellation, then the opponent's addition.
  assign sum_1 = {2'b00, pending_1} - (ack_1 ? {4'd0, inject_rows_1} : 7'd0)
                 - {2'b00, cancel_1} + {2'b00, rem_2};
  assign sum_2 = {2'b00, pending_2} - (ack_2 ? {4'd0, inject_rows_2} : 7'd0)
                 - {2'b00, cancel_2} + {2'b00, rem_1};

  assign ls_sum_1 = {1'b0, line_sended}   + {4'd0, atk_1};
  assign ls_sum_2 = {1'b0, line_sended_2} + {4'd0, atk_2};

  assign hole_raw = {1'b0, lfsr[3:0]};
  assign hole_new = (hole_raw >= COLS) ? 4'(hole_raw - COLS) : lfsr[3:0];

  always_comb begin
    state_1_n   = state_1;
    state_2_n   = state_2;
    rows_1_n    = inject_rows_1;
    rows_2_n    = inject_rows_2;
    hole_1_n    = inject_hole_1;
    hole_2_n    = inject_hole_2;
    pending_1_n = (sum_1 > MAXP) ? MAXP[4:0] : sum_1[4:0];
    pending_2_n = (sum_2 > MAXP) ? MAXP[4:0] : sum_2[4:0];
    ls_1_n      = line_sended;
    ls_2_n      = line_sended_2;
    ko_1_n      = ko;
    ko_2_n      = ko_2;

    if (!game_en || top_1) pending_1_n = 5'd0;
    if (!game_en || top_2) pending_2_n = 5'd0;

    if (!game_en || top_1) state_1_n = IDLE;
    else if (state_1 == IDLE) begin
      if (lk_1 && !clear_valid_1 && pending_1 != 5'd0) begin
        state_1_n = REQ;
        rows_1_n  = ({2'b00, MAXI} < {2'b00, pending_1}) ? MAXI[2:0] : pending_1[2:0];
        hole_1_n  = hole_new;
      end
    end else if (ack_1) state_1_n = IDLE;

    if (!game_en || top_2) state_2_n = IDLE;
    else if (state_2 == IDLE) begin
      if (lk_2 && !clear_valid_2 && pending_2 != 5'd0) begin
        state_2_n = REQ;
        rows_2_n  = ({2'b00, MAXI} < {2'b00, pending_2}) ? MAXI[2:0] : pending_2[2:0];
        hole_2_n  = hole_new;
      end
    end else if (ack_2) state_2_n = IDLE;

    if (rise) begin
      ls_1_n = 6'd0;
      ls_2_n = 6'd0;
      ko_1_n = 3'd0;
      ko_2_n = 3'd0;
    end else begin
      if (clr_1) ls_1_n = (ls_sum_1 > 7'd63) ? 6'd63 : ls_sum_1[5:0];
      if (clr_2) ls_2_n = (ls_sum_2 > 7'd63) ? 6'd63 : ls_sum_2[5:0];
      if (top_2 && ko   != 3'd5) ko_1_n = ko + 3'd1;
      if (top_1 && ko_2 != 3'd5) ko_2_n = ko_2 + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_1       <= IDLE;
      state_2       <= IDLE;
      inject_rows_1 <= 3'd0;
      inject_rows_2 <= 3'd0;
      inject_hole_1 <= 4'd0;
      inject_hole_2 <= 4'd0;
      pending_1     <= 5'd0;
      pending_2     <= 5'd0;
      line_sended   <= 6'd0;
      line_sended_2 <= 6'd0;
      ko            <= 3'd0;
      ko_2          <= 3'd0;
      game_en_q     <= 1'b0;
      lfsr          <= LFSR_SEED;
    end else begin
      state_1       <= state_1_n;
      state_2       <= state_2_n;
      inject_rows_1 <= rows_1_n;
      inject_rows_2 <= rows_2_n;
      inject_hole_1 <= hole_1_n;
      inject_hole_2 <= hole_2_n;
      pending_1     <= pending_1_n;
      pending_2     <= pending_2_n;
      line_sended   <= ls_1_n;
      line_sended_2 <= ls_2_n;
      ko            <= ko_1_n;
      ko_2          <= ko_2_n;
      game_en_q     <= game_en;
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign inject_req_1 = (state_1 == REQ);
  assign inject_req_2 = (state_2 == REQ);

endmodule

// File: tb/tb_garbage_scheduler.sv
module tb_garbage_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_en = 1'b0;
  logic       lock_1 = 0, lock_2 = 0, clear_valid_1 = 0, clear_valid_2 = 0;
  logic [2:0] clear_lines_1 = 0, clear_lines_2 = 0;
  logic       topout_1 = 0, topout_2 = 0, inject_ack_1 = 0, inject_ack_2 = 0;
  logic       inject_req_1, inject_req_2;
  logic [2:0] inject_rows_1, inject_rows_2;
  logic [3:0] inject_hole_1, inject_hole_2;
  logic [4:0] pending_1, pending_2;
  logic [5:0] line_sended, line_sended_2;
  logic [2:0] ko, ko_2;

  int checks = 0;
  int errors = 0;
  int exp_q1[$];
  int exp_q2[$];

  garbage_scheduler dut (
    .clk(clk), .rst_n(rst_n), .game_en(game_en),
    .lock_1(lock_1), .lock_2(lock_2),
    .clear_valid_1(clear_valid_1), .clear_valid_2(clear_valid_2),
    .clear_lines_1(clear_lines_1), .clear_lines_2(clear_lines_2),
    .topout_1(topout_1), .topout_2(topout_2),
    .inject_ack_1(inject_ack_1), .inject_ack_2(inject_ack_2),
    .inject_req_1(inject_req_1), .inject_req_2(inject_req_2),
    .inject_rows_1(inject_rows_1), .inject_rows_2(inject_rows_2),
    .inject_hole_1(inject_hole_1), .inject_hole_2(inject_hole_2),
    .pending_1(pending_1), .pending_2(pending_2),
    .line_sended(line_sended), .line_sended_2(line_sended_2),
    .ko(ko), .ko_2(ko_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per injection burst.
  logic       req_q[2];
  logic [2:0] cap_rows[2];
  logic [3:0] cap_hole[2];
  logic       unstable[2];

  task automatic mon(input int p, input logic req, input logic [2:0] rows, input logic [3:0] hole);
    int e;
    if (req && !req_q[p]) begin
      if ((p == 0 ? exp_q1.size() : exp_q2.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req p%0d actual=1 required=0", p + 1);
      end else begin
        e = (p == 0) ? exp_q1.pop_front() : exp_q2.pop_front();
        chk($sformatf("rows_p%0d", p + 1), int'(rows), e);
        chk($sformatf("hole_range_p%0d", p + 1), int'(hole < 4'd10), 1);
      end
      cap_rows[p] = rows;
      cap_hole[p] = hole;
      unstable[p] = 1'b0;
    end else if (req && req_q[p]) begin
      if (rows != cap_rows[p] || hole != cap_hole[p]) unstable[p] = 1'b1;
    end else if (!req && req_q[p]) begin
      chk($sformatf("req_stable_p%0d", p + 1), int'(unstable[p]), 0);
    end
    req_q[p] = req;
  endtask

  initial begin
    req_q[0] = 0; req_q[1] = 0; unstable[0] = 0; unstable[1] = 0;
    cap_rows[0] = 0; cap_rows[1] = 0; cap_hole[0] = 0; cap_hole[1] = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, inject_req_1, inject_rows_1, inject_hole_1);
      mon(1, inject_req_2, inject_rows_2, inject_hole_2);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle pulse. p: 1 or 2; lines = 0 means lock without clear.
  task automatic lock_clear(input int p, input int lines);
    if (p == 1) begin
      lock_1 = 1; clear_valid_1 = (lines != 0); clear_lines_1 = 3'(lines);
    end else begin
      lock_2 = 1; clear_valid_2 = (lines != 0); clear_lines_2 = 3'(lines);
    end
    tick(1);
    lock_1 = 0; clear_valid_1 = 0; clear_lines_1 = 0;
    lock_2 = 0; clear_valid_2 = 0; clear_lines_2 = 0;
  endtask

  task automatic topout(input logic t1, input logic t2);
    topout_1 = t1; topout_2 = t2;
    tick(1);
    topout_1 = 0; topout_2 = 0;
  endtask

  task automatic ack(input int p);
    if (p == 1) inject_ack_1 = 1; else inject_ack_2 = 1;
    tick(1);
    inject_ack_1 = 0; inject_ack_2 = 0;
  endtask

  task automatic wait_req(input int p);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if ((p == 1 ? inject_req_1 : inject_req_2) == 1'b1) begin
        seen = 1;
        break;
      end
      tick(1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL req_timeout p%0d actual=0 required=1", p);
    end
  endtask

  // Non-clearing lock on player p, expect a burst of `rows`, then ack it.
  task automatic burst(input int p, input int rows);
    if (p == 1) exp_q1.push_back(rows); else exp_q2.push_back(rows);
    lock_clear(p, 0);
    wait_req(p);
    tick(1);
    ack(p);
  endtask

  initial begin
    #1;
    chk("reset_req_1", int'(inject_req_1), 0);
    chk("reset_pending_2", int'(pending_2), 0);
    chk("reset_ko", int'(ko), 0);
    tick(2);
    rst_n = 1;
    game_en = 1;
    tick(2);
    chk("reset_line_sended", int'(line_sended), 0);
    chk("reset_pending_1", int'(pending_1), 0);

    // P1 tetris with nothing pending -> 4 rows to P2.
    lock_clear(1, 4);
    chk("tetris_pending_2", int'(pending_2), 4);
    chk("tetris_line_sended", int'(line_sended), 4);
    burst(2, 4);
    chk("after_ack_pending_2", int'(pending_2), 0);
    chk("after_ack_req_low", int'(inject_req_2), 0);

    // P2 sends 1+2 = 3 to P1; P1 clears 3 (A=2) cancels 2.
    lock_clear(2, 2);
    lock_clear(2, 3);
    chk("p2_sent_pending_1", int'(pending_1), 3);
    chk("p2_line_sended", int'(line_sended_2), 3);
    lock_clear(1, 3);
    chk("cancel_pending_1", int'(pending_1), 1);
    chk("cancel_pending_2", int'(pending_2), 0);
    chk("cancel_line_sended", int'(line_sended), 6);

    // In-flight rows are not cancellable.
    exp_q1.push_back(1);
    lock_clear(1, 0);
    wait_req(1);
    lock_clear(1, 4);
    chk("inflight_pending_1", int'(pending_1), 1);
    chk("inflight_pending_2", int'(pending_2), 4);
    chk("inflight_line_sended", int'(line_sended), 10);
    ack(1);
    chk("inflight_ack_pending_1", int'(pending_1), 0);
    burst(2, 4);
    chk("drain_pending_2", int'(pending_2), 0);

    // Saturation at 12 then three bursts of 4.
    for (int i = 0; i < 4; i++) lock_clear(1, 4);
    chk("sat_pending_2", int'(pending_2), 12);
    chk("sat_line_sended", int'(line_sended), 26);
    for (int i = 0; i < 3; i++) begin
      burst(2, 4);
      chk("burst_pending_2", int'(pending_2), 8 - 4 * i);
    end

    // Long wait without ack, then topout aborts the request.
    lock_clear(1, 4);
    exp_q2.push_back(4);
    lock_clear(2, 0);
    wait_req(2);
    tick(10);
    chk("held_req_2", int'(inject_req_2), 1);
    topout(0, 1);
    chk("topout_ko", int'(ko), 1);
    chk("topout_pending_2", int'(pending_2), 0);
    chk("topout_req_low", int'(inject_req_2), 0);
    for (int i = 0; i < 5; i++) topout(0, 1);
    chk("ko_sat", int'(ko), 5);
    chk("ko_2_zero", int'(ko_2), 0);

    // game_en low clears pending, ignores pulses, holds counters.
    lock_clear(1, 4);
    game_en = 0;
    lock_clear(1, 4);
    tick(1);
    chk("en_low_pending_2", int'(pending_2), 0);
    chk("en_low_line_sended", int'(line_sended), 34);
    chk("en_low_ko", int'(ko), 5);
    game_en = 1;
    tick(1);
    chk("rise_ko", int'(ko), 0);
    chk("rise_line_sended", int'(line_sended), 0);
    chk("rise_line_sended_2", int'(line_sended_2), 0);

    topout(1, 1);
    chk("both_ko", int'(ko), 1);
    chk("both_ko_2", int'(ko_2), 1);

    // Topout beats a same-cycle clear.
    topout_1 = 1;
    lock_clear(1, 4);
    topout_1 = 0;
    chk("topout_wins_ko_2", int'(ko_2), 2);
    chk("topout_wins_pending_2", int'(pending_2), 0);
    chk("topout_wins_line_sended", int'(line_sended), 0);

    // Three consecutive double clears.
    lock_clear(1, 2);
    chk("combo1_line_sended", int'(line_sended), 1);
    lock_clear(1, 2);
`ifdef GARBAGE_COMBO_EN
    chk("combo2_line_sended", int'(line_sended), 3);
    lock_clear(1, 2);
    chk("combo3_line_sended", int'(line_sended), 5);
    chk("combo_pending_2", int'(pending_2), 5);
`else
    chk("combo2_line_sended", int'(line_sended), 2);
    lock_clear(1, 2);
    chk("combo3_line_sended", int'(line_sended), 3);
    chk("combo_pending_2", int'(pending_2), 3);
`endif

    // Ack while idle is ignored.
    ack(2);
`ifdef GARBAGE_COMBO_EN
    chk("idle_ack_pending_2", int'(pending_2), 5);
`else
    chk("idle_ack_pending_2", int'(pending_2), 3);
`endif

    tick(3);
    chk("scoreboard_empty", exp_q1.size() + exp_q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
